// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle WIDTH-bit adder, CHUNK bits per clock through a
//               registered carry, with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH  = 8,
    parameter int CHUNK  = 1,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int c_steps = WIDTH / CHUNK;
    localparam int c_cnt_w = $clog2(c_steps) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_add  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    generate
        if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("serial_adder: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_c;
    logic [CHUNK:0]     w_chunk;
    logic [WIDTH-1:0]   w_a_next;
    logic               w_msb_cin;
    logic               w_ovf;
    logic               w_last;

    assign w_chunk   = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + (CHUNK+1)'(r_c);
    // r_a doubles as the sum shift register: result chunks enter at the top
    // as operand chunks leave at the bottom.
    assign w_a_next  = WIDTH'({w_chunk[CHUNK-1:0], r_a} >> CHUNK);
    assign w_msb_cin = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_chunk[CHUNK-1];
    assign w_ovf     = (SIGNED != 0) ? (w_msb_cin ^ w_chunk[CHUNK]) : w_chunk[CHUNK];
    assign w_last    = (r_cnt == c_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            c_st_idle: begin
                in_ready = !reset;
                if (in_valid) begin
                    w_state_next = c_st_add;
                end
            end
            c_st_add: begin
                if (w_last) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_c   <= carry_in;
                        r_cnt <= '0;
                    end
                end
                c_st_add: begin
                    r_a   <= w_a_next;
                    r_b   <= r_b >> CHUNK;
                    r_c   <= w_chunk[CHUNK];
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        sum      <= w_a_next;
                        carry    <= w_chunk[CHUNK];
                        overflow <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder over six WIDTH=8 configs
//               (CHUNK 1/4/8 x SIGNED 0/1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] iv = '0;
    logic [5:0] ordy = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    wire  [5:0] irdy;
    wire  [5:0] ov;
    wire  [5:0] cy;
    wire  [5:0] of;
    wire  [7:0] sm [6];

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   lat_o [6];
    logic [7:0] obs_s [6];
    logic obs_c [6];
    logic obs_o [6];

    always #5 clk = ~clk;

    // dut0/1: CHUNK 1, dut2/3: CHUNK 4, dut4/5: CHUNK 8; odd index is signed
    for (genvar g = 0; g < 6; g++) begin : g_dut
        serial_adder #(
            .WIDTH (8),
            .CHUNK ((g < 2) ? 1 : ((g < 4) ? 4 : 8)),
            .SIGNED(g % 2)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .in_valid (iv[g]),
            .in_ready (irdy[g]),
            .a        (a),
            .b        (b),
            .carry_in (cin),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .sum      (sm[g]),
            .carry    (cy[g]),
            .overflow (of[g])
        );
    end

    function automatic int lat_of(int g);
        return (g < 2) ? 8 : ((g < 4) ? 2 : 1);
    endfunction

    function automatic exp_t model(int g, logic [7:0] x, logic [7:0] y, logic ci);
        logic [8:0] t;
        exp_t e;
        t     = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        e.idx = 3'(g);
        e.s   = t[7:0];
        e.c   = t[8];
        e.o   = (g % 2 == 1) ? ((x[7] == y[7]) && (t[7] != x[7])) : t[8];
        return e;
    endfunction

    task automatic accept(input logic [5:0] m, input logic [7:0] x, input logic [7:0] y,
                          input logic ci, input bit push);
        int w;
        w = 0;
        @(negedge clk);
        a = x; b = y; cin = ci; iv = m;
        while ((irdy & m) != m && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        iv = '0;
        if (push) for (int g = 0; g < 6; g++) if (m[g]) sb.push_back(model(g, x, y, ci));
    endtask

    // Counts edges after acceptance until each selected DUT raises out_valid;
    // a DUT that never does keeps latency -1.
    task automatic collect(input logic [5:0] m);
        logic [5:0] got;
        got = '0;
        for (int g = 0; g < 6; g++) lat_o[g] = -1;
        for (int k = 1; k <= 12 && got != m; k++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 6; g++) begin
                if (m[g] && !got[g] && ov[g]) begin
                    got[g] = 1'b1; lat_o[g] = k;
                    obs_s[g] = sm[g]; obs_c[g] = cy[g]; obs_o[g] = of[g];
                end
            end
        end
    endtask

    task automatic release_out(input logic [5:0] m);
        @(negedge clk);
        ordy = m;
        @(posedge clk);
        #1;
        ordy = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 6; g++) begin
            checks++; if (irdy[g] !== 1'b0) begin errors++; $display("FAIL reset_in_ready dut%0d: got %b expected 0", g, irdy[g]); end
            checks++; if (ov[g] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b expected 0", g, ov[g]); end
            checks++; if ({sm[g], cy[g], of[g]} !== 10'd0) begin errors++; $display("FAIL reset_outputs dut%0d: got %h expected 000", g, {sm[g], cy[g], of[g]}); end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (irdy !== 6'h3f) begin errors++; $display("FAIL idle_in_ready: got %b expected 111111", irdy); end
    endtask

    task automatic test_add();
        logic [16:0] ops [5] = '{{8'h0F, 8'h01, 1'b0}, {8'hFF, 8'h01, 1'b0},
                                 {8'hFF, 8'hFF, 1'b1}, {8'h7F, 8'h01, 1'b0},
                                 {8'h80, 8'hFF, 1'b0}};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            accept(6'b000011, ops[i][16:9], ops[i][8:1], ops[i][0], 1'b1);
            collect(6'b000011);
            for (int g = 0; g < 2; g++) begin
                e = sb.pop_front();
                checks++; if (lat_o[g] !== lat_of(g)) begin errors++; $display("FAIL add_latency op%0d dut%0d: got %0d expected %0d", i, g, lat_o[g], lat_of(g)); end
                checks++; if (obs_s[g] !== e.s) begin errors++; $display("FAIL add_sum op%0d dut%0d: got %h expected %h", i, g, obs_s[g], e.s); end
                checks++; if (obs_c[g] !== e.c) begin errors++; $display("FAIL add_carry op%0d dut%0d: got %b expected %b", i, g, obs_c[g], e.c); end
                checks++; if (obs_o[g] !== e.o) begin errors++; $display("FAIL add_overflow op%0d dut%0d: got %b expected %b", i, g, obs_o[g], e.o); end
            end
            release_out(6'b000011);
        end
    endtask

    task automatic test_backpressure();
        exp_t ex [2];
        exp_t e;
        accept(6'b000011, 8'h12, 8'h34, 1'b1, 1'b1);
        collect(6'b000011);
        for (int g = 0; g < 2; g++) ex[g] = sb.pop_front();
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b0; iv = 6'b000011;
        repeat (5) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                checks++; if (ov[g] !== 1'b1 || irdy[g] !== 1'b0) begin errors++; $display("FAIL bp_handshake dut%0d: got valid=%b ready=%b expected valid=1 ready=0", g, ov[g], irdy[g]); end
                checks++; if ({sm[g], cy[g], of[g]} !== {ex[g].s, ex[g].c, ex[g].o}) begin errors++; $display("FAIL bp_hold dut%0d: got %h expected %h", g, {sm[g], cy[g], of[g]}, {ex[g].s, ex[g].c, ex[g].o}); end
            end
        end
        for (int g = 0; g < 2; g++) sb.push_back(model(g, 8'hFF, 8'hFF, 1'b0));
        @(negedge clk);
        ordy = 6'b000011;
        @(posedge clk);
        #1;
        ordy = '0;
        checks++; if (ov[1:0] !== 2'b00 || irdy[1:0] !== 2'b11) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=00 ready=11", ov[1:0], irdy[1:0]); end
        checks++; if (sm[0] !== ex[0].s) begin errors++; $display("FAIL bp_sum_after_release: got %h expected %h", sm[0], ex[0].s); end
        @(posedge clk);
        #1;
        iv = '0;
        checks++; if (irdy[1:0] !== 2'b00) begin errors++; $display("FAIL bp_next_accept: got ready=%b expected 00", irdy[1:0]); end
        collect(6'b000011);
        for (int g = 0; g < 2; g++) begin
            e = sb.pop_front();
            checks++; if (lat_o[g] !== lat_of(g)) begin errors++; $display("FAIL bp_latency dut%0d: got %0d expected %0d", g, lat_o[g], lat_of(g)); end
            checks++; if ({obs_s[g], obs_c[g], obs_o[g]} !== {e.s, e.c, e.o}) begin errors++; $display("FAIL bp_result dut%0d: got %h expected %h", g, {obs_s[g], obs_c[g], obs_o[g]}, {e.s, e.c, e.o}); end
        end
        release_out(6'b000011);
    endtask

    task automatic test_abort();
        exp_t e;
        accept(6'b000011, 8'hAA, 8'h55, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++; if (ov[g] !== 1'b0 || irdy[g] !== 1'b0) begin errors++; $display("FAIL abort_handshake dut%0d: got valid=%b ready=%b expected 0 0", g, ov[g], irdy[g]); end
            checks++; if ({sm[g], cy[g], of[g]} !== 10'd0) begin errors++; $display("FAIL abort_outputs dut%0d: got %h expected 000", g, {sm[g], cy[g], of[g]}); end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (irdy[1:0] !== 2'b11) begin errors++; $display("FAIL abort_ready_after: got %b expected 11", irdy[1:0]); end
        accept(6'b000011, 8'h01, 8'h02, 1'b0, 1'b1);
        collect(6'b000011);
        for (int g = 0; g < 2; g++) begin
            e = sb.pop_front();
            checks++; if (lat_o[g] !== lat_of(g)) begin errors++; $display("FAIL abort_latency dut%0d: got %0d expected %0d", g, lat_o[g], lat_of(g)); end
            checks++; if ({obs_s[g], obs_c[g], obs_o[g]} !== {e.s, e.c, e.o}) begin errors++; $display("FAIL abort_result dut%0d: got %h expected %h", g, {obs_s[g], obs_c[g], obs_o[g]}, {e.s, e.c, e.o}); end
        end
        release_out(6'b000011);
    endtask

    task automatic test_chunks();
        logic [16:0] corners [6] = '{{8'h00, 8'h00, 1'b0}, {8'hFF, 8'hFF, 1'b1},
                                     {8'h7F, 8'h00, 1'b1}, {8'h80, 8'h80, 1'b0},
                                     {8'h80, 8'h7F, 1'b1}, {8'h7F, 8'h7F, 1'b0}};
        logic [16:0] op;
        exp_t e;
        for (int i = 0; i < 306; i++) begin
            op = (i < 6) ? corners[i] : 17'($urandom_range(0, 17'h1FFFF));
            accept(6'b111100, op[16:9], op[8:1], op[0], 1'b1);
            collect(6'b111100);
            for (int g = 2; g < 6; g++) begin
                e = sb.pop_front();
                checks++; if (lat_o[g] !== lat_of(g)) begin errors++; $display("FAIL chunk_latency op=%h dut%0d: got %0d expected %0d", op, g, lat_o[g], lat_of(g)); end
                checks++; if (obs_s[g] !== e.s) begin errors++; $display("FAIL chunk_sum op=%h dut%0d: got %h expected %h", op, g, obs_s[g], e.s); end
                checks++; if (obs_c[g] !== e.c) begin errors++; $display("FAIL chunk_carry op=%h dut%0d: got %b expected %b", op, g, obs_c[g], e.c); end
                checks++; if (obs_o[g] !== e.o) begin errors++; $display("FAIL chunk_overflow op=%h dut%0d: got %b expected %b", op, g, obs_o[g], e.o); end
            end
            release_out(6'b111100);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_abort();
        test_chunks();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
